switch_drop_stats: RTL and testbench

SWITCH_DROP_STATS -- requirements
Module: switch_drop_stats

---
 rtl/switch_stats_pkg.sv | 14 +
 rtl/switch_drop_stats_if.sv | 19 +
 rtl/sat_counter.sv | 35 +++
 rtl/switch_drop_stats.sv | 132 +++++++++++++
 tb/tb_switch_drop_stats.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/switch_stats_pkg.sv
// Shared types and default widths for the switch drop-statistics block.
package switch_stats_pkg;

  localparam int DEF_CNT_W  = 32;
  localparam int DEF_FCNT_W = 4;

  typedef enum logic [1:0] {
    SEL_ACC   = 2'd0,
    SEL_DROP  = 2'd1,
    SEL_EDROP = 2'd2,
    SEL_WMARK = 2'd3
  } rd_sel_e;

endpackage

// File: rtl/switch_drop_stats_if.sv
// Statistics read bus: requester drives rd_en/rd_port/rd_sel, the block answers one cycle later.
interface switch_drop_stats_if
  import switch_stats_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int CNT_W   = DEF_CNT_W
);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic             rd_en;
  logic [PW-1:0]    rd_port;
  rd_sel_e          rd_sel;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;

  modport master (output rd_en, rd_port, rd_sel, input  rd_valid, rd_data);
  modport slave  (input  rd_en, rd_port, rd_sel, output rd_valid, rd_data);

endinterface

// File: rtl/sat_counter.sv
// Saturating accumulator with synchronous clear and sticky overflow flag.
module sat_counter #(
  parameter int CNT_W = 32,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] sum,
  output logic             sat
);
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   wide_sum;
  logic [CNT_W:0]   wide_clr;

  assign wide_sum = {1'b0, cnt_q} + (CNT_W+1)'(inc);
  assign wide_clr = (CNT_W+1)'(inc);
  // sum ignores clr so a same-cycle snapshot sees the pre-clear total
  assign sum      = wide_sum[CNT_W] ? '1 : wide_sum[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sat   <= 1'b0;
    end else if (clr) begin
      cnt_q <= wide_clr[CNT_W] ? '1 : wide_clr[CNT_W-1:0];
      sat   <= wide_clr[CNT_W];
    end else begin
      cnt_q <= sum;
      sat   <= sat | wide_sum[CNT_W];
    end
  end

endmodule

// File: rtl/switch_drop_stats.sv
// Per-port accept/drop/egress-drop statistics with snapshot shadows and a read port.
// Optional FIFO high-watermark tracking: define SWITCH_DROP_STATS_WMARK_EN.
module switch_drop_stats
  import switch_stats_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int FCNT_W  = DEF_FCNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          valid_in,
  input  logic [N_PORTS*N_PORTS-1:0]  target_in,
  input  logic [N_PORTS-1:0]          fifo_full,
  input  logic [N_PORTS*FCNT_W-1:0]   fifo_count,
  input  logic                        clr,
  input  logic                        snap,
  switch_drop_stats_if.slave          rd,
  output logic [N_PORTS-1:0]          sat_flag
);
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int EW = $clog2(N_PORTS + 1);

  logic [CNT_W-1:0]   acc_sum   [N_PORTS];
  logic [CNT_W-1:0]   drop_sum  [N_PORTS];
  logic [CNT_W-1:0]   edrop_sum [N_PORTS];
  logic [CNT_W-1:0]   sh_acc    [N_PORTS];
  logic [CNT_W-1:0]   sh_drop   [N_PORTS];
  logic [CNT_W-1:0]   sh_edrop  [N_PORTS];
  logic [N_PORTS-1:0] acc_sat, drop_sat, edrop_sat;
  logic [CNT_W-1:0]   rd_mux;
  logic               in_range;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    logic          acc_hit;
    logic          drop_hit;
    logic [EW-1:0] edrop_inc;

    assign acc_hit   = valid_in[p] & ~fifo_full[p];
    assign drop_hit  = valid_in[p] &  fifo_full[p];
    assign edrop_inc = drop_hit ? EW'($countones(target_in[p*N_PORTS +: N_PORTS])) : '0;

    sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_acc (
      .clk(clk), .rst(rst), .clr(clr), .inc(acc_hit), .sum(acc_sum[p]), .sat(acc_sat[p])
    );
    sat_counter #(.CNT_W(CNT_W), .INC_W(1)) u_drop (
      .clk(clk), .rst(rst), .clr(clr), .inc(drop_hit), .sum(drop_sum[p]), .sat(drop_sat[p])
    );
    sat_counter #(.CNT_W(CNT_W), .INC_W(EW)) u_edrop (
      .clk(clk), .rst(rst), .clr(clr), .inc(edrop_inc), .sum(edrop_sum[p]), .sat(edrop_sat[p])
    );
  end

  assign sat_flag = acc_sat | drop_sat | edrop_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        sh_acc[p]   <= '0;
        sh_drop[p]  <= '0;
        sh_edrop[p] <= '0;
      end
    end else if (snap) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        sh_acc[p]   <= acc_sum[p];
        sh_drop[p]  <= drop_sum[p];
        sh_edrop[p] <= edrop_sum[p];
      end
    end
  end

`ifdef SWITCH_DROP_STATS_WMARK_EN
  logic [FCNT_W-1:0] wm_q   [N_PORTS];
  logic [FCNT_W-1:0] wm_max [N_PORTS];
  logic [CNT_W-1:0]  sh_wm  [N_PORTS];

  always_comb begin
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      wm_max[p] = (fifo_count[p*FCNT_W +: FCNT_W] > wm_q[p]) ? fifo_count[p*FCNT_W +: FCNT_W] : wm_q[p];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        wm_q[p]  <= '0;
        sh_wm[p] <= '0;
      end
    end else begin
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        wm_q[p] <= clr ? fifo_count[p*FCNT_W +: FCNT_W] : wm_max[p];
        if (snap) sh_wm[p] <= CNT_W'(wm_max[p]);
      end
    end
  end
`else
  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;
`endif

  if ((1 << PW) == N_PORTS) begin : g_full_range
    assign in_range = 1'b1;
  end else begin : g_part_range
    assign in_range = ({1'b0, rd.rd_port} < (PW+1)'(N_PORTS));
  end

  always_comb begin
    rd_mux = '0;
    if (in_range) begin
      case (rd.rd_sel)
        SEL_ACC:   rd_mux = sh_acc[rd.rd_port];
        SEL_DROP:  rd_mux = sh_drop[rd.rd_port];
        SEL_EDROP: rd_mux = sh_edrop[rd.rd_port];
`ifdef SWITCH_DROP_STATS_WMARK_EN
        SEL_WMARK: rd_mux = sh_wm[rd.rd_port];
`endif
        default:   rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd.rd_valid <= 1'b0;
      rd.rd_data  <= '0;
    end else begin
      rd.rd_valid <= rd.rd_en;
      if (rd.rd_en) rd.rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_switch_drop_stats.sv
// Bench for switch_drop_stats: a 4-port 32-bit instance against a reference model,
// plus a 6-port 4-bit instance for saturation and out-of-range reads.
module tb_switch_drop_stats;
  import switch_stats_pkg::*;

  localparam int NP  = 4;
  localparam int SNP = 6;
  localparam int SCW = 4;
  localparam longint unsigned MAXV = 64'h0000_0000_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]     valid, ffull, sat;
  logic [NP*NP-1:0]  target;
  logic [NP*4-1:0]   fcount;
  logic              clr, snap;
  logic [SNP-1:0]    s_valid, s_ffull, s_sat;
  logic [SNP*SNP-1:0] s_target;
  logic [SNP*4-1:0]  s_fcount;
  logic              s_clr, s_snap;

  switch_drop_stats_if #(.N_PORTS(NP),  .CNT_W(32))  rd_if ();
  switch_drop_stats_if #(.N_PORTS(SNP), .CNT_W(SCW)) s_rd ();

  switch_drop_stats #(.N_PORTS(NP), .CNT_W(32), .FCNT_W(4)) u_dut (
    .clk(clk), .rst(rst), .valid_in(valid), .target_in(target), .fifo_full(ffull),
    .fifo_count(fcount), .clr(clr), .snap(snap), .rd(rd_if.slave), .sat_flag(sat)
  );

  switch_drop_stats #(.N_PORTS(SNP), .CNT_W(SCW), .FCNT_W(4)) u_small (
    .clk(clk), .rst(rst), .valid_in(s_valid), .target_in(s_target), .fifo_full(s_ffull),
    .fifo_count(s_fcount), .clr(s_clr), .snap(s_snap), .rd(s_rd.slave), .sat_flag(s_sat)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model of the 4-port instance: live totals, shadows, expected read response
  longint unsigned m_acc[NP], m_drop[NP], m_edrop[NP], m_wm[NP];
  longint unsigned h_acc[NP], h_drop[NP], h_edrop[NP], h_wm[NP];
  logic [NP-1:0]   m_sat;
  logic            exp_valid;
  logic [31:0]     exp_data;

  function automatic longint unsigned clamp(longint unsigned v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  function automatic longint unsigned lmax(longint unsigned a, longint unsigned b);
    return (a > b) ? a : b;
  endfunction

  task automatic tick();
    int rp;
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        m_acc[p] = 0; m_drop[p] = 0; m_edrop[p] = 0; m_wm[p] = 0;
        h_acc[p] = 0; h_drop[p] = 0; h_edrop[p] = 0; h_wm[p] = 0;
      end
      m_sat = '0; exp_valid = 1'b0; exp_data = '0;
    end else begin
      exp_valid = rd_if.rd_en;
      if (rd_if.rd_en) begin
        rp = int'(rd_if.rd_port);
        case (rd_if.rd_sel)
          SEL_ACC:   exp_data = 32'(h_acc[rp]);
          SEL_DROP:  exp_data = 32'(h_drop[rp]);
          SEL_EDROP: exp_data = 32'(h_edrop[rp]);
`ifdef SWITCH_DROP_STATS_WMARK_EN
          SEL_WMARK: exp_data = 32'(h_wm[rp]);
`endif
          default:   exp_data = '0;
        endcase
      end
      for (int p = 0; p < NP; p++) begin
        longint unsigned ia, id, ie, fc;
        ia = (valid[p] && !ffull[p]) ? 1 : 0;
        id = (valid[p] &&  ffull[p]) ? 1 : 0;
        ie = id ? $countones(target[p*NP +: NP]) : 0;
        fc = fcount[p*4 +: 4];
        if (snap) begin
          h_acc[p]   = clamp(m_acc[p] + ia);
          h_drop[p]  = clamp(m_drop[p] + id);
          h_edrop[p] = clamp(m_edrop[p] + ie);
          h_wm[p]    = lmax(m_wm[p], fc);
        end
        if (clr) begin
          m_sat[p]   = (ia > MAXV) || (id > MAXV) || (ie > MAXV);
          m_acc[p]   = clamp(ia);
          m_drop[p]  = clamp(id);
          m_edrop[p] = clamp(ie);
          m_wm[p]    = fc;
        end else begin
          m_sat[p]   = m_sat[p] || (m_acc[p] + ia > MAXV) || (m_drop[p] + id > MAXV) ||
                       (m_edrop[p] + ie > MAXV);
          m_acc[p]   = clamp(m_acc[p] + ia);
          m_drop[p]  = clamp(m_drop[p] + id);
          m_edrop[p] = clamp(m_edrop[p] + ie);
          m_wm[p]    = lmax(m_wm[p], fc);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = '0; ffull = '0; target = '0; fcount = '0; clr = 1'b0; snap = 1'b0;
    s_valid = '0; s_ffull = '0; s_target = '0; s_fcount = '0; s_clr = 1'b0; s_snap = 1'b0;
    rd_if.rd_en = 1'b0; rd_if.rd_port = '0; rd_if.rd_sel = SEL_ACC;
    s_rd.rd_en = 1'b0;  s_rd.rd_port = '0;  s_rd.rd_sel = SEL_ACC;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; valid = '1; ffull = 4'b0101; target = '1; rd_if.rd_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    idle();
    total++; if (rd_if.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %0b want 0", rd_if.rd_valid); end
    total++; if (rd_if.rd_data !== '0) begin bad++; $display("FAIL reset_rd_data: got %0d want 0", rd_if.rd_data); end
    total++; if (sat !== '0) begin bad++; $display("FAIL reset_sat: got %b want 0", sat); end
    total++; if (s_sat !== '0 || s_rd.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_small: sat %b valid %0b want 0", s_sat, s_rd.rd_valid); end
    for (int p = 0; p < NP; p++) begin
      for (int s = 0; s < 4; s++) begin
        rd_if.rd_en = 1'b1; rd_if.rd_port = 2'(p); rd_if.rd_sel = rd_sel_e'(s);
        tick();
        total++;
        if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 32'd0) begin
          bad++; $display("FAIL reset_shadow p%0d s%0d: got %0d/%0b want 0/1", p, s, rd_if.rd_data, rd_if.rd_valid);
        end
      end
    end
    idle();
  endtask

  task automatic test_basic();
    logic [31:0] want [3];
    want = '{32'd5, 32'd3, 32'd9};
    do_reset();
    valid = 4'b0001;
    repeat (5) tick();
    ffull = 4'b0001; target[3:0] = 4'b0111;
    repeat (3) tick();
    idle(); snap = 1'b1; tick(); snap = 1'b0;
    for (int s = 0; s < 3; s++) begin
      rd_if.rd_en = 1'b1; rd_if.rd_port = 2'd0; rd_if.rd_sel = rd_sel_e'(s);
      tick();
      total++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== want[s]) begin
        bad++; $display("FAIL basic_port0 sel%0d: got %0d want %0d", s, rd_if.rd_data, want[s]);
      end
    end
    idle();
  endtask

  task automatic test_zero_mask();
    logic [31:0] want [3];
    logic [1:0]  wport [3];
    rd_sel_e     wsel [3];
    want  = '{32'd2, 32'd0, 32'd4};
    wport = '{2'd3, 2'd3, 2'd2};
    wsel  = '{SEL_DROP, SEL_EDROP, SEL_EDROP};
    do_reset();
    valid = 4'b1100; ffull = 4'b1100; target = 16'h0F00;
    tick();
    valid = 4'b1000;
    tick();
    idle(); snap = 1'b1; tick(); snap = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_if.rd_en = 1'b1; rd_if.rd_port = wport[i]; rd_if.rd_sel = wsel[i];
      tick();
      total++;
      if (rd_if.rd_data !== want[i]) begin
        bad++; $display("FAIL zero_mask %0d: got %0d want %0d", i, rd_if.rd_data, want[i]);
      end
    end
    idle();
  endtask

  task automatic test_clr_snap();
    do_reset();
    valid = 4'b0010; ffull = 4'b0010; target[7:4] = 4'b0001;
    repeat (2) tick();
    clr = 1'b1; snap = 1'b1;
    tick();
    idle();
    rd_if.rd_en = 1'b1; rd_if.rd_port = 2'd1; rd_if.rd_sel = SEL_DROP;
    tick();
    total++; if (rd_if.rd_data !== 32'd3) begin bad++; $display("FAIL clr_snap_shadow: got %0d want 3", rd_if.rd_data); end
    rd_if.rd_en = 1'b0; snap = 1'b1;
    tick();
    snap = 1'b0; rd_if.rd_en = 1'b1;
    tick();
    total++; if (rd_if.rd_data !== 32'd1) begin bad++; $display("FAIL clr_snap_live: got %0d want 1", rd_if.rd_data); end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < NP; c++) begin
      valid = 4'(4'hF << c);
      tick();
    end
    idle(); snap = 1'b1; tick(); snap = 1'b0;
    for (int p = 0; p < NP; p++) begin
      rd_if.rd_en = 1'b1; rd_if.rd_port = 2'(p); rd_if.rd_sel = SEL_ACC;
      tick();
      total++;
      if (rd_if.rd_valid !== 1'b1 || rd_if.rd_data !== 32'(p + 1)) begin
        bad++; $display("FAIL b2b_port%0d: got %0d/%0b want %0d/1", p, rd_if.rd_data, rd_if.rd_valid, p + 1);
      end
    end
    rd_if.rd_en = 1'b0;
    tick();
    total++;
    if (rd_if.rd_valid !== 1'b0 || rd_if.rd_data !== 32'd4) begin
      bad++; $display("FAIL b2b_hold: got %0d/%0b want 4/0", rd_if.rd_data, rd_if.rd_valid);
    end
    idle();
  endtask

  task automatic test_reset_midop();
    do_reset();
    valid = '1;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; valid = '0; snap = 1'b1;
    tick();
    snap = 1'b0;
    for (int p = 0; p < NP; p++) begin
      rd_if.rd_en = 1'b1; rd_if.rd_port = 2'(p); rd_if.rd_sel = SEL_ACC;
      tick();
      total++;
      if (rd_if.rd_data !== 32'd0) begin bad++; $display("FAIL reset_midop_port%0d: got %0d want 0", p, rd_if.rd_data); end
    end
    idle();
  endtask

  task automatic test_wmark();
    logic [31:0] want3;
`ifdef SWITCH_DROP_STATS_WMARK_EN
    want3 = 32'd8;
`else
    want3 = 32'd0;
`endif
    do_reset();
    for (int v = 0; v <= 8; v++) begin fcount[15:12] = 4'(v); tick(); end
    for (int v = 7; v >= 2; v--) begin fcount[15:12] = 4'(v); tick(); end
    idle(); snap = 1'b1; tick(); snap = 1'b0;
    rd_if.rd_en = 1'b1; rd_if.rd_port = 2'd3; rd_if.rd_sel = SEL_WMARK;
    tick();
    total++; if (rd_if.rd_data !== want3) begin bad++; $display("FAIL wmark_port3: got %0d want %0d", rd_if.rd_data, want3); end
    rd_if.rd_port = 2'd0;
    tick();
    total++; if (rd_if.rd_data !== 32'd0) begin bad++; $display("FAIL wmark_port0: got %0d want 0", rd_if.rd_data); end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 500; i++) begin
      valid  = NP'($urandom);
      ffull  = NP'($urandom);
      target = 16'($urandom);
      fcount = 16'($urandom);
      clr    = ($urandom_range(0, 19) == 0);
      snap   = ($urandom_range(0, 5) == 0);
      rst    = ($urandom_range(0, 199) == 0);
      rd_if.rd_en   = 1'($urandom_range(0, 1));
      rd_if.rd_port = 2'($urandom_range(0, 3));
      rd_if.rd_sel  = rd_sel_e'($urandom_range(0, 3));
      tick();
      total++;
      if (rd_if.rd_valid !== exp_valid) begin bad++; $display("FAIL rand_valid c%0d: got %0b want %0b", i, rd_if.rd_valid, exp_valid); end
      total++;
      if (rd_if.rd_data !== exp_data) begin bad++; $display("FAIL rand_data c%0d: got %0d want %0d", i, rd_if.rd_data, exp_data); end
      total++;
      if (sat !== m_sat) begin bad++; $display("FAIL rand_sat c%0d: got %b want %b", i, sat, m_sat); end
    end
    rst = 1'b0;
    idle();
  endtask

  task automatic test_saturation();
    do_reset();
    s_valid = 6'b000100;
    for (int i = 0; i < 17; i++) begin
      s_snap = (i == 16);
      tick();
    end
    s_valid = '0; s_snap = 1'b0;
    total++; if (s_sat !== 6'b000100) begin bad++; $display("FAIL sat_flag_set: got %b want 000100", s_sat); end
    s_rd.rd_en = 1'b1; s_rd.rd_port = 3'd2; s_rd.rd_sel = SEL_ACC;
    tick();
    total++; if (s_rd.rd_valid !== 1'b1 || s_rd.rd_data !== 4'd15) begin bad++; $display("FAIL sat_acc2: got %0d want 15", s_rd.rd_data); end
    s_rd.rd_port = 3'd7;
    tick();
    total++; if (s_rd.rd_valid !== 1'b1 || s_rd.rd_data !== 4'd0) begin bad++; $display("FAIL oor_port7: got %0d/%0b want 0/1", s_rd.rd_data, s_rd.rd_valid); end
    s_rd.rd_port = 3'd6;
    tick();
    total++; if (s_rd.rd_valid !== 1'b1 || s_rd.rd_data !== 4'd0) begin bad++; $display("FAIL oor_port6: got %0d/%0b want 0/1", s_rd.rd_data, s_rd.rd_valid); end
    s_rd.rd_en = 1'b0; s_clr = 1'b1;
    tick();
    s_clr = 1'b0;
    total++; if (s_sat !== 6'b000000) begin bad++; $display("FAIL sat_flag_clr: got %b want 000000", s_sat); end
    s_snap = 1'b1;
    tick();
    s_snap = 1'b0; s_rd.rd_en = 1'b1; s_rd.rd_port = 3'd2;
    tick();
    total++; if (s_rd.rd_data !== 4'd0) begin bad++; $display("FAIL sat_acc2_clr: got %0d want 0", s_rd.rd_data); end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_mask();
    test_clr_snap();
    test_back_to_back();
    test_reset_midop();
    test_wmark();
    test_random();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
